// File: rtl/eeprom_pkg.sv
// eeprom_pkg: shared EEPROM widths, I2C device prefix and loader state encoding
package eeprom_pkg;
  localparam int EE_ADDR_W = 11;
  localparam int EE_DATA_W = 8;
  localparam logic [3:0] I2C_DEV_PREFIX = 4'b1010;
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_STORE, S_CHECK} ld_state_e;
endpackage

// File: rtl/eeprom_config_loader_timeout.sv
// eeprom_timeout: per-byte read watchdog, expired when the count reaches TIMEOUT_CYCLES-1
module eeprom_timeout #(
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  logic [W-1:0] count_q, count_d;
  assign expired = count_q == W'(TIMEOUT_CYCLES - 1);
  always_comb count_d = clear ? '0 : (enable && !expired) ? count_q + 1'b1 : count_q;
  always_ff @(posedge clk)
    if (rst) count_q <= '0;
    else     count_q <= count_d;
endmodule

// File: rtl/eeprom_config_loader.sv
// eeprom_config_loader: reads NUM_BYTES config bytes from EEPROM and streams them downstream.
// Macro EEPROM_LOADER_CHECKSUM_EN enables the zero-sum checksum check on the loaded bytes.
module eeprom_config_loader
  import eeprom_pkg::*;
#(
  parameter logic [EE_ADDR_W-1:0] BASE_ADDR      = 11'h000,
  parameter int                   NUM_BYTES      = 16,
  parameter int                   TIMEOUT_CYCLES = 200000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [EE_ADDR_W-1:0] ee_addr,
  output logic                 ee_read,
  input  logic [EE_DATA_W-1:0] ee_data,
  input  logic                 ee_data_ready,
  output logic                 byte_valid,
  output logic [7:0]           byte_index,
  output logic [EE_DATA_W-1:0] byte_data,
  output logic                 checksum_ok
);
  localparam logic [7:0] LAST = 8'(NUM_BYTES - 1);
  ld_state_e state_q, state_d;
  logic [7:0] index_q, index_d;
  logic [EE_DATA_W-1:0] data_q, data_d;
  logic error_q, error_d, done_q, done_d, ok_q, ok_d;
  logic tmr_en, tmr_clear, tmr_expired, sum_ok;

  eeprom_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk(clk), .rst(rst), .clear(tmr_clear), .enable(tmr_en), .expired(tmr_expired)
  );

`ifdef EEPROM_LOADER_CHECKSUM_EN
  logic [EE_DATA_W-1:0] sum_q, sum_d;
  always_comb sum_d = (state_q == S_IDLE && start) ? '0 : (state_q == S_STORE) ? sum_q + data_q : sum_q;
  always_ff @(posedge clk)
    if (rst) sum_q <= '0;
    else     sum_q <= sum_d;
  assign sum_ok = sum_q == '0;
`else
  assign sum_ok = 1'b1;
`endif

  always_ff @(posedge clk)
    if (rst) begin
      state_q <= S_IDLE;
      index_q <= '0;
      data_q  <= '0;
      error_q <= 1'b0;
      done_q  <= 1'b0;
      ok_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      data_q  <= data_d;
      error_q <= error_d;
      done_q  <= done_d;
      ok_q    <= ok_d;
    end

  // done/error/checksum_ok are registered so they land together in the first IDLE cycle
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    data_d  = data_q;
    error_d = error_q;
    ok_d    = ok_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE:
        if (start) begin
          state_d = S_ISSUE;
          index_d = '0;
          error_d = 1'b0;
        end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:
        if (ee_data_ready) begin
          data_d  = ee_data;
          state_d = S_STORE;
        end else if (tmr_expired) begin
          error_d = 1'b1;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      S_STORE: begin
        state_d = (index_q == LAST) ? S_CHECK : S_ISSUE;
        index_d = (index_q == LAST) ? index_q : index_q + 1'b1;
      end
      S_CHECK: begin
        ok_d    = sum_ok;
        error_d = !sum_ok;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy        = state_q != S_IDLE;
    ee_read     = state_q == S_ISSUE;
    byte_valid  = state_q == S_STORE;
    ee_addr     = BASE_ADDR + EE_ADDR_W'(index_q);
    byte_index  = index_q;
    byte_data   = data_q;
    done        = done_q;
    error       = error_q;
    checksum_ok = ok_q;
    tmr_en      = state_q == S_ISSUE || state_q == S_WAIT;
    tmr_clear   = !tmr_en;
  end
endmodule

// File: tb/tb_eeprom_config_loader.sv
// tb_eeprom_config_loader: directed scoreboard bench with an in-bench EEPROM responder model
module tb_eeprom_config_loader;
  localparam logic [10:0] BASE = 11'h7FE;
  localparam int NB = 4;
  localparam int TO = 50;

  logic clk = 1'b0;
  logic rst, start, ee_data_ready;
  logic [7:0] ee_data;
  logic busy, done, error, ee_read, byte_valid, checksum_ok;
  logic [10:0] ee_addr;
  logic [7:0] byte_index, byte_data;

  always #5 clk = ~clk;

  eeprom_config_loader #(.BASE_ADDR(BASE), .NUM_BYTES(NB), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .error(error),
    .ee_addr(ee_addr), .ee_read(ee_read), .ee_data(ee_data), .ee_data_ready(ee_data_ready),
    .byte_valid(byte_valid), .byte_index(byte_index), .byte_data(byte_data),
    .checksum_ok(checksum_ok)
  );

  int n_asserts = 0, n_fails = 0;
  int cyc = 0, n_reads = 0, n_done = 0, n_bv = 0, pend = 0, resp_delay = 2;
  int exp_read_cyc = -1, last_read_cyc = 0, done_cyc = 0;
  int r0, d0, b0;
  logic [7:0] pend_data;
  logic [7:0] mem [0:2047];
  logic mute_en = 1'b0;
  logic [10:0] mute_addr = '0;
  logic done_err, done_ok, exp_err, exp_ok;
  logic [10:0] exp_addr[$];
  logic [15:0] exp_byte[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [10:0] ea;
    logic [15:0] eb;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    ee_data_ready = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        ee_data_ready = 1'b1;
        ee_data = pend_data;
        exp_read_cyc = cyc + 2;
      end
    end
    if (ee_read) begin
      n_reads++;
      last_read_cyc = cyc;
      chk("read_latency", 32'(cyc), 32'(exp_read_cyc));
      chk("read_expected", 32'(exp_addr.size() != 0), 32'd1);
      if (exp_addr.size() != 0) begin
        ea = exp_addr.pop_front();
        chk("ee_addr", 32'(ee_addr), 32'(ea));
      end
      if (!(mute_en && ee_addr == mute_addr)) begin
        pend = resp_delay;
        pend_data = mem[ee_addr];
      end
    end
    if (byte_valid) begin
      n_bv++;
      chk("byte_expected", 32'(exp_byte.size() != 0), 32'd1);
      if (exp_byte.size() != 0) begin
        eb = exp_byte.pop_front();
        chk("byte_index", 32'(byte_index), 32'(eb[15:8]));
        chk("byte_data", 32'(byte_data), 32'(eb[7:0]));
      end
    end
    if (done) begin
      n_done++;
      done_cyc = cyc;
      done_err = error;
      done_ok = checksum_ok;
    end
  endtask

  task automatic push_load(input int nread, input int nbytes);
    logic [10:0] a;
    for (int i = 0; i < nread; i++) begin
      a = BASE + 11'(i);
      exp_addr.push_back(a);
    end
    for (int i = 0; i < nbytes; i++) begin
      a = BASE + 11'(i);
      exp_byte.push_back({8'(i), mem[a]});
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    exp_read_cyc = cyc + 1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n0 = n_done;
    for (int i = 0; i < budget && n_done == n0; i++) tick();
    chk("done_seen", 32'(n_done - n0), 32'd1);
  endtask

  task automatic start_snap();
    r0 = n_reads;
    d0 = n_done;
    b0 = n_bv;
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 8'h5A;
    mem[11'h7FE] = 8'h01;
    mem[11'h7FF] = 8'h02;
    mem[11'h000] = 8'h03;
    mem[11'h001] = 8'hFA;
    rst = 1'b1; start = 1'b0; ee_data_ready = 1'b0; ee_data = '0;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_ee_read", 32'(ee_read), 0);
    chk("rst_ee_addr", 32'(ee_addr), 32'(BASE));
    chk("rst_byte_valid", 32'(byte_valid), 0);
    chk("rst_byte_index", 32'(byte_index), 0);
    chk("rst_byte_data", 32'(byte_data), 0);
    chk("rst_checksum_ok", 32'(checksum_ok), 0);
    rst = 1'b0;
    tick();

    // good load across the address wrap 7FE..001, sum = 0x100
    start_snap();
    push_load(NB, NB);
    pulse_start();
    chk("busy_after_start", 32'(busy), 1);
    wait_done(300);
    chk("good_reads", 32'(n_reads - r0), NB);
    chk("good_bytes", 32'(n_bv - b0), NB);
    chk("good_error", 32'(done_err), 0);
    chk("good_ok", 32'(done_ok), 1);
    chk("good_busy_idle", 32'(busy), 0);

    // last byte FB breaks the zero sum
    mem[11'h001] = 8'hFB;
`ifdef EEPROM_LOADER_CHECKSUM_EN
    exp_err = 1'b1; exp_ok = 1'b0;
`else
    exp_err = 1'b0; exp_ok = 1'b1;
`endif
    start_snap();
    push_load(NB, NB);
    pulse_start();
    wait_done(300);
    chk("bad_reads", 32'(n_reads - r0), NB);
    chk("bad_error", 32'(done_err), 32'(exp_err));
    chk("bad_ok", 32'(done_ok), 32'(exp_ok));
    tick();
    tick();
    chk("bad_error_sticky", 32'(error), 32'(exp_err));
    chk("bad_done_pulse", 32'(n_done - d0), 1);
    mem[11'h001] = 8'hFA;

    // timeout: byte 2 (address 000) never answered
    mute_en = 1'b1;
    mute_addr = 11'h000;
    start_snap();
    push_load(3, 2);
    pulse_start();
    wait_done(300);
    chk("to_reads", 32'(n_reads - r0), 3);
    chk("to_bytes", 32'(n_bv - b0), 2);
    chk("to_error", 32'(done_err), 1);
    chk("to_done_delay", 32'(done_cyc - last_read_cyc), TO);
    mute_en = 1'b0;
    tick();

    // reset during WAIT of byte 1 with a late answer; reset beats start
    resp_delay = 5;
    start_snap();
    push_load(2, 1);
    pulse_start();
    chk("error_cleared_by_start", 32'(error), 0);
    for (int i = 0; i < 30 && n_reads - r0 < 2; i++) tick();
    chk("rst_test_reads", 32'(n_reads - r0), 2);
    tick();
    rst = 1'b1;
    start = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_ok", 32'(checksum_ok), 0);
    chk("midrst_addr", 32'(ee_addr), 32'(BASE));
    for (int i = 0; i < 8; i++) tick();
    chk("midrst_no_extra_read", 32'(n_reads - r0), 2);
    chk("midrst_bytes", 32'(n_bv - b0), 1);
    chk("midrst_no_done", 32'(n_done - d0), 0);
    chk("midrst_idle", 32'(busy), 0);
    resp_delay = 2;
    start_snap();
    push_load(NB, NB);
    pulse_start();
    wait_done(300);
    chk("post_rst_reads", 32'(n_reads - r0), NB);
    chk("post_rst_error", 32'(done_err), 0);
    chk("post_rst_ok", 32'(done_ok), 1);

    // second start during WAIT must be ignored
    resp_delay = 4;
    start_snap();
    push_load(NB, NB);
    pulse_start();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(300);
    for (int i = 0; i < 10; i++) tick();
    chk("ign_reads", 32'(n_reads - r0), NB);
    chk("ign_dones", 32'(n_done - d0), 1);
    chk("ign_ok", 32'(done_ok), 1);
    chk("queues_drained", 32'(exp_addr.size() + exp_byte.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end
endmodule
